// File: rtl/l0_ctrl_if.sv
// Command, SRAM-port and L0-bank signals of the L0 input-buffer sequencer.
// slave is the sequencer's view; master is the decoder/bank/array side.
interface l0_ctrl_if #(
  parameter int addr_w = 11
);
  logic              start;
  logic [addr_w-1:0] base_addr;
  logic [6:0]        len;
  logic              mode;
  logic              l0_full;
  logic              array_ready;
  logic              sram_rd;
  logic [addr_w-1:0] sram_addr;
  logic              l0_wr;
  logic              l0_rd;
  logic              l0_mode;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, len, mode, l0_full, array_ready,
    output sram_rd, sram_addr, l0_wr, l0_rd, l0_mode, busy, done
  );

  modport master (
    output start, base_addr, len, mode, l0_full, array_ready,
    input  sram_rd, sram_addr, l0_wr, l0_rd, l0_mode, busy, done
  );
endinterface

// File: rtl/l0_ctrl.sv
// L0 input-buffer sequencer: loads a block of vectors from SRAM into the L0
// row FIFOs, drains them into the systolic array, flushes the row skew.
module l0_ctrl #(
  parameter int row    = 8,
  parameter int depth  = 64,
  parameter int addr_w = 11
) (
  input  logic      clk,
  input  logic      reset,
  l0_ctrl_if.slave  bus
);

  localparam int cnt_w   = $clog2(depth + 1);
  localparam int flush_w = $clog2(row + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [addr_w-1:0]  base_q;
  logic [addr_w-1:0]  last_addr_q;
  logic [cnt_w-1:0]   len_q;
  logic [cnt_w-1:0]   issued_q;
  logic [cnt_w-1:0]   written_q;
  logic [cnt_w-1:0]   drained_q;
  logic [flush_w-1:0] flush_q;
  logic               mode_q;
  logic               l0_wr_q;

  logic [cnt_w-1:0]   len_clamped;
  logic [addr_w-1:0]  rd_addr;
  logic               sram_rd;
  logic               l0_rd;
  logic               accept;
  logic               last_write;
  logic               last_drain;
  logic               flush_end;

  always_comb begin
    len_clamped = (int'(bus.len) > depth) ? cnt_w'(depth) : cnt_w'(bus.len);
    accept      = (state_q == IDLE) && bus.start;
    sram_rd     = (state_q == LOAD) && (issued_q < len_q) && !bus.l0_full;
    rd_addr     = base_q + addr_w'(issued_q);
    l0_rd       = (state_q == DRAIN) && bus.array_ready;
    last_write  = l0_wr_q && (cnt_w'(written_q + 1'b1) == len_q);
    last_drain  = l0_rd && (cnt_w'(drained_q + 1'b1) == len_q);
    // Mode 1 staggers rows, so the last row's read lands row cycles later.
    flush_end   = mode_q ? (flush_q == flush_w'(row - 1)) : 1'b1;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (len_clamped == '0) ? DONE : LOAD;
      LOAD:    if (last_write) state_d = DRAIN;
      DRAIN:   if (last_drain) state_d = FLUSH;
      FLUSH:   if (flush_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      last_addr_q <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      written_q   <= '0;
      drained_q   <= '0;
      flush_q     <= '0;
      mode_q      <= 1'b0;
      l0_wr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // SRAM read latency is one cycle: data is valid for L0 the next cycle.
      l0_wr_q <= sram_rd;

      if (accept) begin
        base_q    <= bus.base_addr;
        len_q     <= len_clamped;
        mode_q    <= bus.mode;
        issued_q  <= '0;
        written_q <= '0;
        drained_q <= '0;
      end else begin
        if (sram_rd) issued_q  <= issued_q + 1'b1;
        if (l0_wr_q) written_q <= written_q + 1'b1;
        if (l0_rd)   drained_q <= drained_q + 1'b1;
      end

      // Address output holds its last issued value between reads.
      if (sram_rd) last_addr_q <= rd_addr;

      flush_q <= (state_q == FLUSH) ? flush_q + 1'b1 : '0;
    end
  end

  assign bus.sram_rd   = sram_rd;
  assign bus.sram_addr = sram_rd ? rd_addr : last_addr_q;
  assign bus.l0_wr     = l0_wr_q;
  assign bus.l0_rd     = l0_rd;
  assign bus.l0_mode   = mode_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_l0_ctrl.sv
// Self-checking bench for l0_ctrl: directed test-plan scenarios plus random
// commands, compared cycle by cycle against an event-schedule reference model.
module tb_l0_ctrl;

  localparam int ROW    = 8;
  localparam int DEPTH  = 64;
  localparam int MAXC   = 600;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  l0_ctrl_if #(.addr_w(11)) bus ();

  l0_ctrl #(.row(ROW), .depth(DEPTH), .addr_w(11)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle input schedules for a command (cycle 1 = first cycle after start).
  bit          full_s  [MAXC];
  bit          ready_s [MAXC];
  bit          start_s [MAXC];
  logic [10:0] exp_last_addr;

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      full_s[i]  = 1'b0;
      ready_s[i] = 1'b1;
      start_s[i] = 1'b0;
    end
  endtask

  // Drive one command and compare every output in every cycle against the
  // expected event schedule derived from the command and stall schedules.
  task automatic run_cmd(input string name, input logic [10:0] base,
                         input logic [6:0] len, input logic mode,
                         output int done_cyc, output int n_rd, output int n_wr,
                         output int n_l0rd, output logic [10:0] last_rd_addr);
    bit          e_rd   [MAXC];
    bit          e_wr   [MAXC];
    bit          e_l0rd [MAXC];
    logic [10:0] e_addr [MAXC];
    int          eff;
    int          t;
    int          e_done;
    logic [5:0]  obs;
    logic [5:0]  expv;
    logic [10:0] want_addr;

    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_wr[i] = 0; e_l0rd[i] = 0; e_addr[i] = '0;
    end
    eff = (int'(len) > DEPTH) ? DEPTH : int'(len);
    if (eff == 0) begin
      e_done = 1;
    end else begin
      t = 1;
      for (int i = 0; i < eff; i++) begin
        while (full_s[t] && t < MAXC - 100) t++;
        e_rd[t]   = 1;
        e_addr[t] = 11'(base + 11'(i));
        e_wr[t+1] = 1;
        t++;
      end
      t++;  // first drain opportunity: the cycle after the last write
      for (int i = 0; i < eff; i++) begin
        while (!ready_s[t] && t < MAXC - 30) t++;
        e_l0rd[t] = 1;
        t++;
      end
      e_done = t + (mode ? ROW : 1);
    end

    done_cyc = -1; n_rd = 0; n_wr = 0; n_l0rd = 0; last_rd_addr = '0;

    bus.start       = 1'b1;
    bus.base_addr   = base;
    bus.len         = len;
    bus.mode        = mode;
    bus.l0_full     = 1'b0;
    bus.array_ready = 1'b0;

    for (int c = 1; c <= e_done + 1; c++) begin
      @(posedge clk);
      #2;
      bus.start       = (c <= e_done) ? start_s[c] : 1'b0;
      if (start_s[c]) begin
        bus.base_addr = 11'($urandom);
        bus.len       = 7'($urandom);
        bus.mode      = 1'($urandom);
      end
      bus.l0_full     = full_s[c];
      bus.array_ready = ready_s[c];
      #1;
      if (e_rd[c]) exp_last_addr = e_addr[c];
      want_addr = exp_last_addr;
      obs  = {bus.sram_rd, bus.l0_wr, bus.l0_rd, bus.busy, bus.done, bus.l0_mode};
      expv = {e_rd[c], e_wr[c], e_l0rd[c], (c <= e_done), (c == e_done), mode};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d rd/wr/l0rd/busy/done/mode got %b expected %b",
                 name, c, obs, expv);
      end
      checks++;
      if (bus.sram_addr !== want_addr) begin
        errors++;
        $display("FAIL %s cycle %0d sram_addr got %h expected %h",
                 name, c, bus.sram_addr, want_addr);
      end
      if (bus.sram_rd === 1'b1) begin
        n_rd++;
        last_rd_addr = bus.sram_addr;
      end
      if (bus.l0_wr === 1'b1) n_wr++;
      if (bus.l0_rd === 1'b1) n_l0rd++;
      if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    logic [16:0] obs;
    obs = {bus.sram_rd, bus.l0_wr, bus.l0_rd, bus.busy, bus.done, bus.l0_mode,
           bus.sram_addr};
    checks++;
    if (obs !== 17'h0) begin
      errors++;
      $display("FAIL %s outputs got %h expected 0", name, obs);
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.base_addr   = '0;
    bus.len         = '0;
    bus.mode        = 1'b0;
    bus.l0_full     = 1'b0;
    bus.array_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_idle_outputs("reset_held");
    reset = 1'b0;
    @(posedge clk);
    #3;
    check_idle_outputs("after_reset");
    exp_last_addr = '0;
  endtask

  task automatic test_basic_mode0();
    int dc, nr, nw, nl; logic [10:0] la;
    clear_sched();
    run_cmd("basic_m0", 11'h010, 7'd4, 1'b0, dc, nr, nw, nl, la);
    check_int("basic_m0 done cycle", dc, 11);
    check_int("basic_m0 reads", nr, 4);
    check_int("basic_m0 writes", nw, 4);
    check_int("basic_m0 drains", nl, 4);
    check_int("basic_m0 last addr", int'(la), 'h013);
  endtask

  task automatic test_mode1_skew();
    int dc, nr, nw, nl; logic [10:0] la;
    clear_sched();
    run_cmd("skew_m1", 11'h010, 7'd4, 1'b1, dc, nr, nw, nl, la);
    check_int("skew_m1 done cycle", dc, 18);
    check_int("skew_m1 drains", nl, 4);
  endtask

  task automatic test_backpressure();
    int dc, nr, nw, nl; logic [10:0] la;
    clear_sched();
    ready_s[7] = 1'b0;
    ready_s[8] = 1'b0;
    run_cmd("backpressure", 11'h010, 7'd4, 1'b0, dc, nr, nw, nl, la);
    check_int("backpressure done cycle", dc, 13);
    check_int("backpressure drains", nl, 4);
  endtask

  task automatic test_full_wrap();
    int dc, nr, nw, nl; logic [10:0] la;
    clear_sched();
    full_s[2] = 1'b1;
    run_cmd("full_wrap", 11'h7FE, 7'd4, 1'b0, dc, nr, nw, nl, la);
    check_int("full_wrap done cycle", dc, 12);
    check_int("full_wrap writes", nw, 4);
    check_int("full_wrap last addr", int'(la), 'h001);
  endtask

  task automatic test_edge_lengths();
    int dc, nr, nw, nl; logic [10:0] la;
    clear_sched();
    run_cmd("len_zero", 11'h055, 7'd0, 1'b1, dc, nr, nw, nl, la);
    check_int("len_zero done cycle", dc, 1);
    check_int("len_zero strobes", nr + nw + nl, 0);
    clear_sched();
    run_cmd("len_clamp", 11'h100, 7'd100, 1'b0, dc, nr, nw, nl, la);
    check_int("len_clamp reads", nr, 64);
    check_int("len_clamp writes", nw, 64);
    check_int("len_clamp drains", nl, 64);
    check_int("len_clamp done cycle", dc, 2 * 64 + 3);
  endtask

  task automatic test_start_ignored();
    int dc, nr, nw, nl; logic [10:0] la;
    clear_sched();
    for (int c = 1; c < 20; c++) start_s[c] = 1'b1;
    run_cmd("start_busy", 11'h200, 7'd5, 1'b1, dc, nr, nw, nl, la);
    check_int("start_busy done cycle", dc, 2 * 5 + 2 + ROW);
    check_int("start_busy reads", nr, 5);
  endtask

  task automatic test_reset_mid_load();
    int dc, nr, nw, nl; logic [10:0] la;
    bus.start     = 1'b1;
    bus.base_addr = 11'h300;
    bus.len       = 7'd8;
    bus.mode      = 1'b1;
    bus.l0_full   = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      if (c == 3) reset = 1'b1;
      #1;
      checks++;
      if (bus.sram_rd !== 1'b1 || bus.sram_addr !== 11'(11'h300 + 11'(c - 1))) begin
        errors++;
        $display("FAIL rst_mid cycle %0d read got %b/%h expected 1/%h", c,
                 bus.sram_rd, bus.sram_addr, 11'(11'h300 + 11'(c - 1)));
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid cycle4");
    @(posedge clk);
    #3;
    check_idle_outputs("rst_mid cycle5");
    exp_last_addr = '0;
    clear_sched();
    run_cmd("after_rst", 11'h040, 7'd3, 1'b0, dc, nr, nw, nl, la);
    check_int("after_rst done cycle", dc, 9);
  endtask

  task automatic test_random();
    int dc, nr, nw, nl; logic [10:0] la;
    logic [6:0] len;
    int eff;
    for (int n = 0; n < 20; n++) begin
      clear_sched();
      for (int c = 1; c < MAXC; c++) begin
        full_s[c]  = ($urandom_range(0, 3) == 0);
        ready_s[c] = ($urandom_range(0, 3) != 0);
        start_s[c] = ($urandom_range(0, 7) == 0);
      end
      len = 7'($urandom_range(0, 72));
      eff = (int'(len) > DEPTH) ? DEPTH : int'(len);
      run_cmd("random", 11'($urandom), len, 1'($urandom), dc, nr, nw, nl, la);
      check_int("random drains", nl, eff);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_last_addr = '0;
    test_reset();
    test_basic_mode0();
    test_mode1_skew();
    test_backpressure();
    test_full_wrap();
    test_edge_lengths();
    test_start_ignored();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
